// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler: FSM states, the latched
// operation record, flag bit positions and the multiply command codes.
`include "defines.sv"

package alu_sched_pkg;

    localparam int OP_WIDTH  = `OP_WIDTH;
    localparam int CMD_WIDTH = `CMD_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Bit positions inside the 6-bit {ERR,OFLOW,COUT,G,L,E} flag vector.
    localparam int FLAG_E     = 0;
    localparam int FLAG_L     = 1;
    localparam int FLAG_G     = 2;
    localparam int FLAG_COUT  = 3;
    localparam int FLAG_OFLOW = 4;
    localparam int FLAG_ERR   = 5;

    // Arithmetic-mode commands that take the long multiply path.
    localparam logic [CMD_WIDTH-1:0] CMD_MUL_INC = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] CMD_MUL_SHL = CMD_WIDTH'(10);

    // One operation as handed to the ALU.
    typedef struct packed {
        logic                 mode;
        logic [CMD_WIDTH-1:0] cmd;
        logic [OP_WIDTH-1:0]  opa;
        logic [OP_WIDTH-1:0]  opb;
        logic                 cin;
    } alu_op_t;

    // True when the operation uses the multiply latency.
    function automatic logic is_mul(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester whenever a grant is accepted.
module alu_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    // Index of the requester that wins when both are asking.
    logic prio_q;
    logic prio_d;

    // Grant selection and priority update.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        grant_o = 2'b00;
        prio_d  = prio_q;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
        if (accept_i && (grant_o != 2'b00)) begin
            prio_d = ~grant_o[1];
        end
    end

    // Priority register; requester 0 is favoured out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/defines.sv
// Datapath widths shared by the ALU and everything that talks to it.
`ifndef ALU_SCHED_DEFINES_SV
`define ALU_SCHED_DEFINES_SV

`define OP_WIDTH  8
`define CMD_WIDTH 4

`endif

// File: rtl/alu_scheduler.sv
// Front end for a multi-cycle ALU: arbitrates two requesters, issues one
// operation at a time, waits out the command-dependent latency and returns
// the registered result to the requester that owned the operation.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int LAT_NORM = 1,
    parameter int LAT_MUL  = 3
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_mode,
    input  logic [2*CMD_WIDTH-1:0]  req_cmd,
    input  logic [2*OP_WIDTH-1:0]   req_opa,
    input  logic [2*OP_WIDTH-1:0]   req_opb,
    input  logic [1:0]              req_cin,
    output logic                    alu_ce,
    output logic [1:0]              alu_inp_valid,
    output logic                    alu_mode,
    output logic [CMD_WIDTH-1:0]    alu_cmd,
    output logic [OP_WIDTH-1:0]     alu_opa,
    output logic [OP_WIDTH-1:0]     alu_opb,
    output logic                    alu_cin,
    input  logic [OP_WIDTH:0]       alu_res,
    input  logic [5:0]              alu_flags,
    output logic [1:0]              rsp_valid,
    output logic [OP_WIDTH:0]       rsp_res,
    output logic [5:0]              rsp_flags
);

    localparam int LAT_MAX = (LAT_MUL > LAT_NORM) ? LAT_MUL : LAT_NORM;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               gidx_q,      gidx_d;
    alu_op_t            op_q,        op_d;
    logic [OP_WIDTH:0]  rsp_res_q,   rsp_res_d;
    logic [5:0]         rsp_flags_q, rsp_flags_d;

    logic [1:0]         grant;
    logic               accept;
    logic               sel;
    alu_op_t            sel_op;

    alu_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (RST),
        .req_i    (req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Operation fields of whichever requester the arbiter currently favours.
    assign sel    = grant[1];
    assign sel_op = {req_mode[sel],
                     sel ? req_cmd[2*CMD_WIDTH-1:CMD_WIDTH] : req_cmd[CMD_WIDTH-1:0],
                     sel ? req_opa[2*OP_WIDTH-1:OP_WIDTH]   : req_opa[OP_WIDTH-1:0],
                     sel ? req_opb[2*OP_WIDTH-1:OP_WIDTH]   : req_opb[OP_WIDTH-1:0],
                     req_cin[sel]};

    // Next-state logic and per-state outputs of the issue/wait/respond FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gidx_d        = gidx_q;
        op_d          = op_q;
        rsp_res_d     = rsp_res_q;
        rsp_flags_d   = rsp_flags_q;
        req_ready     = 2'b00;
        accept        = 1'b0;
        alu_ce        = 1'b0;
        alu_inp_valid = 2'b00;
        rsp_valid     = 2'b00;
        unique case (state_q)
            IDLE: begin
                // Ready is gated by reset too, so it drops the instant RST falls.
                req_ready = RST ? grant : 2'b00;
                accept    = |(req_valid & req_ready);
                if (accept) begin
                    state_d = ISSUE;
                    gidx_d  = sel;
                    op_d    = sel_op;
                    cnt_d   = is_mul(sel_op.mode, sel_op.cmd) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_NORM);
                end
            end
            ISSUE: begin
                alu_ce        = 1'b1;
                alu_inp_valid = 2'b11;
                state_d       = WAIT;
            end
            WAIT: begin
                alu_ce        = 1'b1;
                alu_inp_valid = 2'b11;
                cnt_d         = cnt_q - CNT_W'(1);
                // The edge that takes the count to zero is exactly LAT edges
                // after the ALU sampled the operation, so capture here.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_res_d   = alu_res;
                    rsp_flags_d = alu_flags;
                end
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, latency counter, latched operation and captured response.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gidx_q      <= 1'b0;
            op_q        <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gidx_q      <= gidx_d;
            op_q        <= op_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign alu_mode  = op_q.mode;
    assign alu_cmd   = op_q.cmd;
    assign alu_opa   = op_q.opa;
    assign alu_opb   = op_q.opb;
    assign alu_cin   = op_q.cin;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: the bench plays the ALU by driving
// alu_res/alu_flags only in the window where the capture edge must see them.
`timescale 1ns/1ps

module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int LAT_NORM = 1;
    localparam int LAT_MUL  = 3;

    logic                   clk = 1'b0;
    logic                   RST;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_mode;
    logic [2*CMD_WIDTH-1:0] req_cmd;
    logic [2*OP_WIDTH-1:0]  req_opa;
    logic [2*OP_WIDTH-1:0]  req_opb;
    logic [1:0]             req_cin;
    logic                   alu_ce;
    logic [1:0]             alu_inp_valid;
    logic                   alu_mode;
    logic [CMD_WIDTH-1:0]   alu_cmd;
    logic [OP_WIDTH-1:0]    alu_opa;
    logic [OP_WIDTH-1:0]    alu_opb;
    logic                   alu_cin;
    logic [OP_WIDTH:0]      alu_res;
    logic [5:0]             alu_flags;
    logic [1:0]             rsp_valid;
    logic [OP_WIDTH:0]      rsp_res;
    logic [5:0]             rsp_flags;

    int checks   = 0;
    int failures = 0;

    alu_scheduler #(
        .LAT_NORM (LAT_NORM),
        .LAT_MUL  (LAT_MUL)
    ) dut (
        .clk           (clk),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_cmd       (req_cmd),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .req_cin       (req_cin),
        .alu_ce        (alu_ce),
        .alu_inp_valid (alu_inp_valid),
        .alu_mode      (alu_mode),
        .alu_cmd       (alu_cmd),
        .alu_opa       (alu_opa),
        .alu_opb       (alu_opb),
        .alu_cin       (alu_cin),
        .alu_res       (alu_res),
        .alu_flags     (alu_flags),
        .rsp_valid     (rsp_valid),
        .rsp_res       (rsp_res),
        .rsp_flags     (rsp_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic mode, input logic [CMD_WIDTH-1:0] cmd,
                           input logic [OP_WIDTH-1:0] a, input logic [OP_WIDTH-1:0] b,
                           input logic cin);
        req_mode[idx]                        = mode;
        req_cmd[idx*CMD_WIDTH +: CMD_WIDTH]  = cmd;
        req_opa[idx*OP_WIDTH +: OP_WIDTH]    = a;
        req_opb[idx*OP_WIDTH +: OP_WIDTH]    = b;
        req_cin[idx]                         = cin;
    endtask

    initial begin
        int         g;
        logic [1:0] eg;
        logic [7:0] ea;

        // ---- reset state, with both requesters asking ----
        RST       = 1'b1;
        req_valid = 2'b11;
        req_mode  = '0;
        req_cmd   = '0;
        req_opa   = '0;
        req_opb   = '0;
        req_cin   = '0;
        alu_res   = '1;
        alu_flags = '1;
        #2 RST = 1'b0;
        step();
        step();
        check("rst_ready",     req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_ce_inp",    {alu_ce, alu_inp_valid}, 3'b000);
        check("rst_alu_fields", {alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin}, 0);
        check("rst_rsp_data",  {rsp_res, rsp_flags}, 0);

        req_valid = 2'b00;
        RST       = 1'b1;
        step();
        check("idle_ready_none", req_ready, 2'b00);

        // ---- req0 MODE=1 CMD=0 5+3, normal latency ----
        set_req(0, 1'b1, 4'd0, 8'd5, 8'd3, 1'b0);
        set_req(1, 1'b1, 4'd9, 8'hAA, 8'h55, 1'b1);
        req_valid = 2'b01;
        alu_res   = 9'h1FF;
        alu_flags = 6'b000000;
        #1 check("t1_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("t1_issue_ce", {alu_ce, alu_inp_valid}, 3'b111);
        check("t1_fields", {alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin},
              {1'b1, 4'd0, 8'd5, 8'd3, 1'b0});
        check("t1_ready_held", req_ready, 2'b00);
        step();
        check("t1_wait_ce", {alu_ce, alu_inp_valid}, 3'b111);
        check("t1_no_rsp_early", rsp_valid, 2'b00);
        alu_res = 9'd8;
        step();
        alu_res = 9'h155;
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_res", rsp_res, 9'd8);
        check("t1_resp_ce", {alu_ce, alu_inp_valid}, 3'b000);
        step();
        check("t1_rsp_once", rsp_valid, 2'b00);
        check("t1_res_held", rsp_res, 9'd8);

        // ---- req1 MODE=1 CMD=9, multiply latency ----
        set_req(1, 1'b1, 4'd9, 8'd7, 8'd6, 1'b0);
        req_valid = 2'b10;
        #1 check("t2_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        alu_res   = 9'h1FF;
        check("t2_fields", {alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin},
              {1'b1, 4'd9, 8'd7, 8'd6, 1'b0});
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_ce_%0d", k), {alu_ce, alu_inp_valid}, 3'b111);
            check($sformatf("t2_no_rsp_%0d", k), rsp_valid, 2'b00);
            if (k == 3) alu_res = 9'd42;
            step();
        end
        alu_res = 9'h1FF;
        check("t2_rsp_valid", rsp_valid, 2'b10);
        check("t2_rsp_res", rsp_res, 9'd42);
        check("t2_resp_ce", {alu_ce, alu_inp_valid}, 3'b000);
        step();
        check("t2_rsp_once", rsp_valid, 2'b00);

        // ---- both requesters held valid: grants alternate 0,1,0,1 ----
        set_req(0, 1'b0, 4'd1, 8'd10, 8'd1, 1'b0);
        set_req(1, 1'b0, 4'd1, 8'd20, 8'd2, 1'b0);
        req_valid = 2'b11;
        alu_flags = 6'b000101;
        for (int i = 0; i < 4; i++) begin
            g  = i % 2;
            eg = (g == 1) ? 2'b10 : 2'b01;
            ea = (g == 1) ? 8'd20 : 8'd10;
            #1 check($sformatf("t3_ready_%0d", i), req_ready, eg);
            step();
            check($sformatf("t3_opa_%0d", i), alu_opa, ea);
            check($sformatf("t3_hold_off_%0d", i), req_ready, 2'b00);
            step();
            alu_res = {1'b0, ea} + 9'd1;
            step();
            alu_res = 9'h1FF;
            check($sformatf("t3_rsp_idx_%0d", i), rsp_valid, eg);
            check($sformatf("t3_rsp_res_%0d", i), rsp_res, {1'b0, ea} + 9'd1);
            step();
        end
        req_valid = 2'b00;
        check("t3_rsp_flags", rsp_flags, 6'b000101);
        alu_flags = 6'b000000;

        // ---- reset during WAIT of a req0 multiply ----
        set_req(0, 1'b1, 4'd10, 8'd3, 8'd4, 1'b0);
        req_valid = 2'b01;
        #1 check("t4_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("t4_cmd", alu_cmd, 4'd10);
        step();
        check("t4_in_wait", {alu_ce, alu_inp_valid}, 3'b111);
        RST = 1'b0;
        #1;
        check("t4_rst_ce_inp", {alu_ce, alu_inp_valid}, 3'b000);
        check("t4_rst_fields", {alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin}, 0);
        check("t4_rst_rsp", {rsp_valid, rsp_res, rsp_flags}, 0);
        step();
        step();
        RST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_no_rsp_%0d", k), rsp_valid, 2'b00);
            step();
        end
        req_valid = 2'b11;
        #1 check("t4_ptr_reset", req_ready, 2'b01);
        req_valid = 2'b00;
        step();

        // ---- req0 MODE=0 CMD=14: ALU error flag passed through ----
        set_req(0, 1'b0, 4'd14, 8'd1, 8'd2, 1'b1);
        req_valid = 2'b01;
        #1 check("t5_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("t5_fields", {alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin},
              {1'b0, 4'd14, 8'd1, 8'd2, 1'b1});
        step();
        alu_res   = 9'd0;
        alu_flags = 6'b100000;
        step();
        alu_flags = 6'b000000;
        check("t5_rsp_valid", rsp_valid, 2'b01);
        check("t5_err_flag", rsp_flags[FLAG_ERR], 1'b1);
        step();
        check("t5_rsp_once", rsp_valid, 2'b00);
        check("t5_flags_held", rsp_flags, 6'b100000);

        // ---- req1 MODE=0 CMD=9 is not a multiply: normal latency ----
        set_req(1, 1'b0, 4'd9, 8'd9, 8'd9, 1'b0);
        req_valid = 2'b10;
        #1 check("t6_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("t6_issue_ce", alu_ce, 1'b1);
        step();
        alu_res = 9'd77;
        step();
        alu_res = 9'h1FF;
        check("t6_rsp_valid", rsp_valid, 2'b10);
        check("t6_rsp_res", rsp_res, 9'd77);
        step();
        check("t6_rsp_once", rsp_valid, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
